// File: rtl/cpu6_useq_pkg.sv
// Shared definitions for the cpu6 microprogram sequencer.
package cpu6_useq_pkg;

   // Instruction encodings on the op input
   localparam logic [2:0] OP_CONT = 3'd0;
   localparam logic [2:0] OP_JUMP = 3'd1;
   localparam logic [2:0] OP_CALL = 3'd2;
   localparam logic [2:0] OP_RET  = 3'd3;
   localparam logic [2:0] OP_LDCT = 3'd4;
   localparam logic [2:0] OP_RPCT = 3'd5;
   localparam logic [2:0] OP_JMAP = 3'd6;
   localparam logic [2:0] OP_JREG = 3'd7;

   // Bit positions inside the sticky fault vector
   localparam int FAULT_OVF = 0;
   localparam int FAULT_UNF = 1;

endpackage

// File: rtl/cpu6_useq_stack.sv
// Return-address LIFO. A push while full is dropped and a pop while empty
// is ignored; both raise a sticky fault bit that only reset clears.
module cpu6_useq_stack
   import cpu6_useq_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] tos,
   output logic              full,
   output logic              empty,
   output logic [1:0]        fault
);

   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [SP_W-1:0]   sp;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  top_idx;

   assign full    = (sp == SP_W'(DEPTH));
   assign empty   = (sp == '0);
   assign wr_idx  = IDX_W'(sp);
   assign top_idx = IDX_W'(sp - SP_W'(1));
   // An empty stack reads as zero so an underflowing return vectors to 0
   assign tos     = empty ? '0 : mem[top_idx];

   // Entry storage; no reset needed since sp gates every read
   always_ff @(posedge clock) begin
      if (push && !full)
         mem[wr_idx] <= push_data;
   end

   // Stack pointer movement and sticky fault capture
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp    <= '0;
         fault <= 2'b00;
      end else begin
         if (push && !full)
            sp <= sp + SP_W'(1);
         else if (pop && !empty)
            sp <= sp - SP_W'(1);
         if (push && full)
            fault[FAULT_OVF] <= 1'b1;
         if (pop && empty)
            fault[FAULT_UNF] <= 1'b1;
      end
   end

endmodule

// File: rtl/cpu6_microsequencer.sv
// Single-block microprogram sequencer driving the microcode ROM address.
// y_out is combinational; uPC, loop counter, R and the return stack
// update on the rising clock edge.
module cpu6_microsequencer
   import cpu6_useq_pkg::*;
#(
   parameter int ADDR_W      = 11,
   parameter int STACK_DEPTH = 4,
   parameter int CNT_W       = 11
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              hold,
   input  logic [2:0]        op,
   input  logic              cc_en,
   input  logic              cc_pol,
   input  logic              cond,
   input  logic              cin,
   input  logic [ADDR_W-1:0] d_in,
   input  logic [ADDR_W-1:0] or_in,
   input  logic [ADDR_W-1:0] map_in,
   input  logic [ADDR_W-1:0] r_in,
   input  logic              r_load,
   output logic [ADDR_W-1:0] y_out,
   output logic              cnt_zero,
   output logic              stack_full,
   output logic              stack_empty,
   output logic [1:0]        fault
);

   logic [ADDR_W-1:0] upc;
   logic [ADDR_W-1:0] r_reg;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] y_op;
   logic [ADDR_W-1:0] tos;
   logic              pass;
   logic              run;
   logic              push;
   logic              pop;
   logic              cnt_load;
   logic              cnt_dec;

   assign pass     = ~cc_en | (cond ^ cc_pol);
   // clear and hold both suppress every side effect of op
   assign run      = ~hold & ~clear;
   assign cnt_zero = (cnt == '0);

   // Decode op into a candidate address and the side effects it requests
   always_comb begin
      y_op     = upc;
      push     = 1'b0;
      pop      = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (op)
         OP_JUMP: if (pass) y_op = d_in | or_in;
         OP_CALL: if (pass) begin
            y_op = d_in | or_in;
            push = 1'b1;
         end
         OP_RET: if (pass) begin
            y_op = tos;
            pop  = 1'b1;
         end
         OP_LDCT: cnt_load = 1'b1;
         OP_RPCT: if (!cnt_zero) begin
            y_op    = d_in;
            cnt_dec = 1'b1;
         end
         OP_JMAP: y_op = map_in;
         OP_JREG: if (pass) y_op = r_reg;
         default: y_op = upc;
      endcase
   end

   // Output priority: reset/clear, then hold, then the decoded op
   always_comb begin
      if (reset || clear)
         y_out = '0;
      else if (hold)
         y_out = upc;
      else
         y_out = y_op;
   end

   // uPC follows the issued address plus carry-in, wrapping at 2^ADDR_W
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         upc <= '0;
      else if (!hold)
         upc <= y_out + ADDR_W'(cin);
   end

   // Loop counter: load, or decrement toward zero without wrapping
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (run && cnt_load)
         cnt <= CNT_W'(d_in);
      else if (run && cnt_dec && !cnt_zero)
         cnt <= cnt - CNT_W'(1);
   end

   // Address register loads regardless of hold; JREG sees the old value
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_reg <= '0;
      else if (r_load)
         r_reg <= r_in;
   end

   cpu6_useq_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (STACK_DEPTH)
   ) u_stack (
      .clock     (clock),
      .reset     (reset),
      .push      (push & run),
      .pop       (pop & run),
      .push_data (upc),
      .tos       (tos),
      .full      (stack_full),
      .empty     (stack_empty),
      .fault     (fault)
   );

endmodule

// File: tb/tb_cpu6_microsequencer.sv
// Directed self-checking bench for cpu6_microsequencer.
module tb_cpu6_microsequencer;
   import cpu6_useq_pkg::*;

   logic        clock = 1'b0;
   logic        reset, clear, hold, cc_en, cc_pol, cond, cin, r_load;
   logic [2:0]  op;
   logic [10:0] d_in, or_in, map_in, r_in, y_out;
   logic        cnt_zero, stack_full, stack_empty;
   logic [1:0]  fault;

   int n_checks = 0;
   int n_fail   = 0;

   cpu6_microsequencer dut (
      .clock(clock), .reset(reset), .clear(clear), .hold(hold), .op(op),
      .cc_en(cc_en), .cc_pol(cc_pol), .cond(cond), .cin(cin), .d_in(d_in),
      .or_in(or_in), .map_in(map_in), .r_in(r_in), .r_load(r_load),
      .y_out(y_out), .cnt_zero(cnt_zero), .stack_full(stack_full),
      .stack_empty(stack_empty), .fault(fault)
   );

   always #5 clock = ~clock;

   task automatic idle();
      clear = 0; hold = 0; op = OP_CONT; cc_en = 0; cc_pol = 0; cond = 0;
      cin = 1; d_in = 0; or_in = 0; map_in = 0; r_in = 0; r_load = 0;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset = 1; #1; reset = 0; #1;
   endtask

   task automatic chk_y(input string name, input logic [10:0] exp);
      n_checks++;
      if (y_out !== exp) begin
         n_fail++;
         $display("FAIL %s: y_out=%h expected %h", name, y_out, exp);
      end
   endtask

   task automatic test_reset();
      idle(); reset = 1; #2;
      n_checks++;
      if ({y_out, cnt_zero, stack_full, stack_empty, fault} !== {11'h000, 1'b1, 1'b0, 1'b1, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_state: y=%h cz=%b full=%b empty=%b fault=%b expected 000 1 0 1 00",
                  y_out, cnt_zero, stack_full, stack_empty, fault);
      end
      reset = 0; #1;
      for (int i = 0; i < 4; i++) begin
         chk_y($sformatf("cont_%0d", i), 11'(i));
         tick();
      end
      // uPC is now 4; assert reset away from an edge
      reset = 1; #1;
      chk_y("mid_reset_async", 11'h000);
      reset = 0; #1;
      chk_y("after_reset", 11'h000);
   endtask

   task automatic test_jump();
      idle(); op = OP_JUMP; d_in = 11'h100; or_in = 11'h006;
      cc_en = 1; cond = 0; cc_pol = 1; #1;
      chk_y("jump_pass", 11'h106);
      tick(); cond = 1; #1;
      chk_y("jump_fail", 11'h107);
      tick();
   endtask

   task automatic test_call();
      logic [10:0] call_tgt [5];
      logic [10:0] ret_exp  [4];
      call_tgt = '{11'h200, 11'h300, 11'h400, 11'h500, 11'h600};
      ret_exp  = '{11'h401, 11'h301, 11'h201, 11'h011};
      do_reset();
      idle(); op = OP_JUMP; d_in = 11'h010; #1;
      chk_y("pre_call_jump", 11'h010);
      tick();
      for (int i = 0; i < 5; i++) begin
         op = OP_CALL; d_in = call_tgt[i]; #1;
         chk_y($sformatf("call_%0d", i), call_tgt[i]);
         tick();
         if (i == 3) begin
            n_checks++;
            if ({stack_full, fault} !== 3'b100) begin
               n_fail++;
               $display("FAIL call_full: full=%b fault=%b expected 1 00", stack_full, fault);
            end
         end
      end
      n_checks++;
      if ({stack_full, fault} !== 3'b101) begin
         n_fail++;
         $display("FAIL call_overflow: full=%b fault=%b expected 1 01", stack_full, fault);
      end
      idle(); op = OP_RET;
      for (int i = 0; i < 4; i++) begin
         #1; chk_y($sformatf("ret_%0d", i), ret_exp[i]);
         tick();
      end
      n_checks++;
      if ({stack_empty, fault} !== 3'b101) begin
         n_fail++;
         $display("FAIL ret_empty: empty=%b fault=%b expected 1 01", stack_empty, fault);
      end
      #1; chk_y("ret_underflow", 11'h000);
      tick();
      n_checks++;
      if (fault !== 2'b11) begin
         n_fail++;
         $display("FAIL underflow_fault: fault=%b expected 11", fault);
      end
      op = OP_CONT; #1;
      chk_y("after_underflow", 11'h001);
   endtask

   task automatic test_loop();
      idle(); op = OP_LDCT; d_in = 11'd3; #1;
      chk_y("ldct", 11'h001);
      tick();
      n_checks++;
      if (cnt_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL ldct_cnt: cnt_zero=%b expected 0", cnt_zero);
      end
      op = OP_RPCT; d_in = 11'h050;
      for (int i = 0; i < 3; i++) begin
         #1; chk_y($sformatf("rpct_%0d", i), 11'h050);
         tick();
         n_checks++;
         if (cnt_zero !== (i == 2)) begin
            n_fail++;
            $display("FAIL rpct_cz_%0d: cnt_zero=%b expected %b", i, cnt_zero, (i == 2));
         end
      end
      #1; chk_y("rpct_fall", 11'h051);
      tick();
   endtask

   task automatic test_jmap_jreg();
      idle(); op = OP_JMAP; map_in = 11'h1A5; #1;
      chk_y("jmap", 11'h1A5);
      tick();
      op = OP_JREG; r_load = 1; r_in = 11'h2C0; #1;
      chk_y("jreg_old_r", 11'h000);
      tick();
      r_load = 0; #1;
      chk_y("jreg_new_r", 11'h2C0);
      tick();
      op = OP_CALL; d_in = 11'h123; hold = 1;
      for (int i = 0; i < 2; i++) begin
         #1; chk_y($sformatf("hold_%0d", i), 11'h2C1);
         tick();
      end
      n_checks++;
      if (stack_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_no_push: stack_empty=%b expected 1", stack_empty);
      end
      hold = 0; op = OP_CONT; #1;
      chk_y("after_hold", 11'h2C1);
      tick();
   endtask

   task automatic test_wrap_clear();
      idle(); op = OP_JUMP; d_in = 11'h7FE; #1;
      chk_y("jump_7fe", 11'h7FE);
      tick();
      op = OP_CONT; #1;
      chk_y("cont_7ff", 11'h7FF);
      tick(); #1;
      chk_y("wrap", 11'h000);
      tick(); tick();
      // uPC is now 2
      clear = 1; op = OP_JUMP; d_in = 11'h555; #1;
      chk_y("clear_y", 11'h000);
      tick();
      clear = 0; op = OP_CONT; #1;
      chk_y("clear_upc", 11'h001);
   endtask

   initial begin
      test_reset();
      test_jump();
      test_call();
      test_loop();
      test_jmap_jreg();
      test_wrap_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
